// File: rtl/jtag_pkg.sv
// TAP state encodings, opcode constants and the IEEE 1149.1 next-state function.
// Latency: none (pure constants and combinational function).
// Backpressure: none.
package jtag_pkg;

  localparam int IR_W = 5;

  // TAP states in the conventional 1149.1 numbering
  localparam logic [3:0] TLR        = 4'd0;
  localparam logic [3:0] RUN_IDLE   = 4'd1;
  localparam logic [3:0] SELECT_DR  = 4'd2;
  localparam logic [3:0] CAPTURE_DR = 4'd3;
  localparam logic [3:0] SHIFT_DR   = 4'd4;
  localparam logic [3:0] EXIT1_DR   = 4'd5;
  localparam logic [3:0] PAUSE_DR   = 4'd6;
  localparam logic [3:0] EXIT2_DR   = 4'd7;
  localparam logic [3:0] UPDATE_DR  = 4'd8;
  localparam logic [3:0] SELECT_IR  = 4'd9;
  localparam logic [3:0] CAPTURE_IR = 4'd10;
  localparam logic [3:0] SHIFT_IR   = 4'd11;
  localparam logic [3:0] EXIT1_IR   = 4'd12;
  localparam logic [3:0] PAUSE_IR   = 4'd13;
  localparam logic [3:0] EXIT2_IR   = 4'd14;
  localparam logic [3:0] UPDATE_IR  = 4'd15;

  localparam logic [IR_W-1:0] OP_IDCODE = 5'h01;
  localparam logic [IR_W-1:0] OP_USER   = 5'h11;
  localparam logic [IR_W-1:0] OP_BYPASS = 5'h1F;

  // Standard TMS-driven transition table
  function automatic logic [3:0] next_state(input logic [3:0] state, input logic tms);
    logic [3:0] nxt;
    nxt = TLR;
    case (state)
      TLR:        nxt = tms ? TLR       : RUN_IDLE;
      RUN_IDLE:   nxt = tms ? SELECT_DR : RUN_IDLE;
      SELECT_DR:  nxt = tms ? SELECT_IR : CAPTURE_DR;
      CAPTURE_DR: nxt = tms ? EXIT1_DR  : SHIFT_DR;
      SHIFT_DR:   nxt = tms ? EXIT1_DR  : SHIFT_DR;
      EXIT1_DR:   nxt = tms ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:   nxt = tms ? EXIT2_DR  : PAUSE_DR;
      EXIT2_DR:   nxt = tms ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR:  nxt = tms ? SELECT_DR : RUN_IDLE;
      SELECT_IR:  nxt = tms ? TLR       : CAPTURE_IR;
      CAPTURE_IR: nxt = tms ? EXIT1_IR  : SHIFT_IR;
      SHIFT_IR:   nxt = tms ? EXIT1_IR  : SHIFT_IR;
      EXIT1_IR:   nxt = tms ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:   nxt = tms ? EXIT2_IR  : PAUSE_IR;
      EXIT2_IR:   nxt = tms ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR:  nxt = tms ? SELECT_DR : RUN_IDLE;
      default:    nxt = TLR;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jtag_tap_os_if.sv
// JTAG pin bundle between the pad driver and the oversampled TAP.
// Latency: none (wires only).
// Backpressure: none; pins are free-running.
interface jtag_tap_os_if;
  logic tck;
  logic tms;
  logic tdi;
  logic tdo;
  logic tdo_oe;

  modport master (output tck, output tms, output tdi, input tdo, input tdo_oe);
  modport slave  (input tck, input tms, input tdi, output tdo, output tdo_oe);
endinterface

// File: rtl/jtag_sync_edge.sv
// Synchronizes tck/tms/tdi into the system clock and produces tck edge pulses.
// Latency: two flops to the edge pulse; tms/tdi come from the same stage as tck.
// Backpressure: none; a tck phase shorter than three clocks may be missed.
module jtag_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic tck,
  input  logic tms,
  input  logic tdi,
  output logic tck_rise,
  output logic tck_fall,
  output logic tms_s,
  output logic tdi_s
);

  logic [2:0] tck_q;
  logic [1:0] tms_q;
  logic [1:0] tdi_q;

  // Two-flop synchronizers plus one extra tck stage for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      tck_q <= '0;
      tms_q <= '0;
      tdi_q <= '0;
    end else begin
      tck_q <= {tck_q[1:0], tck};
      tms_q <= {tms_q[0], tms};
      tdi_q <= {tdi_q[0], tdi};
    end
  end

  // tms/tdi are taken at the same depth as tck_q[1] so they stay aligned to the edge
  assign tck_rise = tck_q[1] & ~tck_q[2];
  assign tck_fall = ~tck_q[1] & tck_q[2];
  assign tms_s    = tms_q[1];
  assign tdi_s    = tdi_q[1];

endmodule

// File: rtl/jtag_tap_os.sv
// IEEE 1149.1 TAP with IDCODE, BYPASS and USER registers, all in the system clock domain.
// Latency: actions land one clock after the synchronized tck edge pulse; tdo moves on tck fall.
// Backpressure: none; the JTAG host paces everything through tck.
module jtag_tap_os
  import jtag_pkg::*;
#(
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0FFF,
  parameter int          USER_W     = 32
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  jtag_tap_os_if.slave       pins,
  output logic [3:0]         tap_state,
  output logic [IR_W-1:0]    ir_o,
  input  logic [USER_W-1:0]  user_cap_i,
  output logic [USER_W-1:0]  user_dr_o,
  output logic               user_upd_o
);

  localparam int DR_W = (USER_W > 32) ? USER_W : 32;

  logic            tck_rise;
  logic            tck_fall;
  logic            tms_s;
  logic            tdi_s;
  logic [3:0]      state;
  logic [3:0]      state_nxt;
  logic [IR_W-1:0] ir_shift;
  logic [DR_W-1:0] dr_shift;
  logic [DR_W-1:0] dr_shift_nxt;
  logic            bypass;
  logic            sel_idcode;
  logic            sel_user;

  jtag_sync_edge u_sync (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .tck      (pins.tck),
    .tms      (pins.tms),
    .tdi      (pins.tdi),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall),
    .tms_s    (tms_s),
    .tdi_s    (tdi_s)
  );

  // Any opcode other than IDCODE or USER falls through to the bypass flop
  assign sel_idcode = (ir_o == OP_IDCODE);
  assign sel_user   = (ir_o == OP_USER);
  assign state_nxt  = next_state(state, tms_s);
  assign tap_state  = state;

  // Shared DR shifts with tdi entering at the MSB of whichever register is selected
  always_comb begin
    dr_shift_nxt = dr_shift;
    if (sel_idcode) begin
      dr_shift_nxt[31:0] = {tdi_s, dr_shift[31:1]};
    end else begin
      dr_shift_nxt[USER_W-1:0] = {tdi_s, dr_shift[USER_W-1:1]};
    end
  end

  // TAP state advances only on a synchronized tck rise
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= TLR;
    end else if (tck_rise) begin
      state <= state_nxt;
    end
  end

  // Instruction register: capture/shift/update, forced to IDCODE whenever the TAP lands in reset
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ir_shift <= '0;
      ir_o     <= OP_IDCODE;
    end else if (tck_rise) begin
      case (state)
        CAPTURE_IR: ir_shift <= {{(IR_W-2){1'b0}}, 2'b01};
        SHIFT_IR:   ir_shift <= {tdi_s, ir_shift[IR_W-1:1]};
        UPDATE_IR:  ir_o     <= ir_shift;
        default:    ;
      endcase
      if (state == TLR || state_nxt == TLR) begin
        ir_o <= OP_IDCODE;
      end
    end
  end

  // Data registers: capture by instruction, shift, and publish USER on Update-DR
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      dr_shift   <= '0;
      bypass     <= 1'b0;
      user_dr_o  <= '0;
      user_upd_o <= 1'b0;
    end else begin
      user_upd_o <= 1'b0;
      if (tck_rise) begin
        case (state)
          CAPTURE_DR: begin
            if (sel_idcode) begin
              dr_shift <= DR_W'(IDCODE_VAL);
            end else if (sel_user) begin
              dr_shift <= DR_W'(user_cap_i);
            end else begin
              bypass <= 1'b0;
            end
          end
          SHIFT_DR: begin
            if (sel_idcode || sel_user) begin
              dr_shift <= dr_shift_nxt;
            end else begin
              bypass <= tdi_s;
            end
          end
          UPDATE_DR: begin
            if (sel_user) begin
              user_dr_o  <= dr_shift[USER_W-1:0];
              user_upd_o <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // tdo changes on tck fall so the host sees a stable bit at the following rise
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      pins.tdo    <= 1'b0;
      pins.tdo_oe <= 1'b0;
    end else if (tck_fall) begin
      if (state == SHIFT_IR) begin
        pins.tdo    <= ir_shift[0];
        pins.tdo_oe <= 1'b1;
      end else if (state == SHIFT_DR) begin
        pins.tdo    <= (sel_idcode || sel_user) ? dr_shift[0] : bypass;
        pins.tdo_oe <= 1'b1;
      end else begin
        pins.tdo    <= 1'b0;
        pins.tdo_oe <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jtag_tap_os.sv
// Directed bench for jtag_tap_os: drives JTAG pins slowly relative to wb_clk_i.
// Latency: tck half periods are several system clocks so every edge is seen.
// Backpressure: none.
module tb_jtag_tap_os;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic [3:0]  tap_state;
  logic [4:0]  ir_o;
  logic [31:0] user_cap_i = '0;
  logic [31:0] user_dr_o;
  logic        user_upd_o;

  int n_chk = 0;
  int n_err = 0;
  int upd_cnt = 0;

  jtag_tap_os_if jif ();

  jtag_tap_os dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .pins       (jif),
    .tap_state  (tap_state),
    .ir_o       (ir_o),
    .user_cap_i (user_cap_i),
    .user_dr_o  (user_dr_o),
    .user_upd_o (user_upd_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Count every system clock during which the update strobe is high
  always @(posedge wb_clk_i) begin
    if (user_upd_o) upd_cnt <= upd_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full tck period; tdo is sampled just before the rising edge
  task automatic tck_pulse(input logic tms_v, input logic tdi_v, output logic tdo_s);
    @(negedge wb_clk_i);
    jif.tms = tms_v;
    jif.tdi = tdi_v;
    repeat (2) @(negedge wb_clk_i);
    tdo_s = jif.tdo;
    jif.tck = 1'b1;
    repeat (4) @(negedge wb_clk_i);
    jif.tck = 1'b0;
    repeat (6) @(negedge wb_clk_i);
  endtask

  task automatic shift_bits(input int n, input logic [63:0] din, output logic [63:0] dout);
    logic b;
    dout = '0;
    for (int i = 0; i < n; i++) begin
      tck_pulse(i == n - 1, din[i], b);
      dout[i] = b;
    end
  endtask

  task automatic goto_shift_dr();
    logic b;
    tck_pulse(1'b1, 1'b0, b);
    tck_pulse(1'b0, 1'b0, b);
    tck_pulse(1'b0, 1'b0, b);
  endtask

  task automatic goto_shift_ir();
    logic b;
    tck_pulse(1'b1, 1'b0, b);
    tck_pulse(1'b1, 1'b0, b);
    tck_pulse(1'b0, 1'b0, b);
    tck_pulse(1'b0, 1'b0, b);
  endtask

  // From Exit1: through Update and back to Run-Test-Idle
  task automatic exit_update();
    logic b;
    tck_pulse(1'b1, 1'b0, b);
    tck_pulse(1'b0, 1'b0, b);
  endtask

  task automatic set_ir(input logic [4:0] op, output logic [63:0] cap);
    goto_shift_ir();
    shift_bits(5, {59'd0, op}, cap);
    exit_update();
  endtask

  initial begin
    logic [63:0] dout;
    logic        b;
    int          c0;

    jif.tck = 1'b0;
    jif.tms = 1'b0;
    jif.tdi = 1'b0;

    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    check_eq("rst_state",  tap_state, 0);
    check_eq("rst_ir",     ir_o, 5'h01);
    check_eq("rst_tdo",    jif.tdo, 0);
    check_eq("rst_tdo_oe", jif.tdo_oe, 0);
    check_eq("rst_user_dr", user_dr_o, 0);
    check_eq("rst_upd",    user_upd_o, 0);

    for (int i = 0; i < 5; i++) tck_pulse(1'b1, 1'b0, b);
    tck_pulse(1'b0, 1'b0, b);
    check_eq("rti_state",  tap_state, 1);
    check_eq("rti_ir",     ir_o, 5'h01);
    check_eq("rti_tdo_oe", jif.tdo_oe, 0);

    // IDCODE read
    goto_shift_dr();
    check_eq("idc_state",  tap_state, 4);
    check_eq("idc_tdo_oe", jif.tdo_oe, 1);
    shift_bits(32, 64'd0, dout);
    check_eq("idcode", dout, 64'h1000_0FFF);
    exit_update();

    // IR capture pattern and BYPASS load
    set_ir(5'h1F, dout);
    check_eq("ir_capture", dout, 64'h01);
    check_eq("ir_bypass",  ir_o, 5'h1F);
    goto_shift_dr();
    shift_bits(9, 64'h0A5, dout);
    check_eq("byp_first", dout[0], 0);
    check_eq("byp_data",  dout[8:1], 8'hA5);
    exit_update();

    // USER write/read
    user_cap_i = 32'hCAFE_F00D;
    set_ir(5'h11, dout);
    check_eq("ir_user", ir_o, 5'h11);
    goto_shift_dr();
    shift_bits(32, 64'h1234_5678, dout);
    check_eq("user_read", dout, 64'hCAFE_F00D);
    c0 = upd_cnt;
    exit_update();
    check_eq("user_dr",  user_dr_o, 32'h1234_5678);
    check_eq("user_upd", upd_cnt - c0, 1);

    // Zero-length shift: Capture -> Exit1 -> Update publishes the captured value
    user_cap_i = 32'h0BAD_BEEF;
    c0 = upd_cnt;
    tck_pulse(1'b1, 1'b0, b);
    tck_pulse(1'b0, 1'b0, b);
    tck_pulse(1'b1, 1'b0, b);
    exit_update();
    check_eq("zlen_dr",  user_dr_o, 32'h0BAD_BEEF);
    check_eq("zlen_upd", upd_cnt - c0, 1);

    // TMS escape from Shift-DR with BYPASS selected
    set_ir(5'h1F, dout);
    goto_shift_dr();
    c0 = upd_cnt;
    for (int i = 0; i < 5; i++) tck_pulse(1'b1, 1'b0, b);
    check_eq("esc_state", tap_state, 0);
    check_eq("esc_ir",    ir_o, 5'h01);
    check_eq("esc_upd",   upd_cnt - c0, 0);
    tck_pulse(1'b0, 1'b0, b);

    // Reset in the middle of a USER scan
    set_ir(5'h11, dout);
    goto_shift_dr();
    for (int i = 0; i < 10; i++) tck_pulse(1'b0, i[0], b);
    check_eq("mid_state", tap_state, 4);
    check_eq("mid_oe",    jif.tdo_oe, 1);
    c0 = upd_cnt;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    check_eq("mrst_state",   tap_state, 0);
    check_eq("mrst_tdo_oe",  jif.tdo_oe, 0);
    check_eq("mrst_tdo",     jif.tdo, 0);
    check_eq("mrst_user_dr", user_dr_o, 0);
    check_eq("mrst_ir",      ir_o, 5'h01);
    wb_rst_i = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    check_eq("mrst_upd", upd_cnt - c0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
